// File: rtl/avalon_interval_timer_gen2_pkg.sv
`default_nettype none
// =============================================================================
// avalon_timer_pkg : register map and bit positions of the interval timer
// Revision: 1.0
// =============================================================================
package avalon_timer_pkg;

   localparam logic [2:0] ADDR_STATUS   = 3'd0;
   localparam logic [2:0] ADDR_CONTROL  = 3'd1;
   localparam logic [2:0] ADDR_PERIODL  = 3'd2;
   localparam logic [2:0] ADDR_PERIODH  = 3'd3;
   localparam logic [2:0] ADDR_SNAPL    = 3'd4;
   localparam logic [2:0] ADDR_SNAPH    = 3'd5;
   localparam logic [2:0] ADDR_PRESCALE = 3'd6;

   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   localparam int STAT_TO  = 0;
   localparam int STAT_RUN = 1;

endpackage
`default_nettype wire

// File: rtl/avalon_interval_timer_gen2_if.sv
`default_nettype none
// =============================================================================
// avalon_interval_timer_gen2_if : 16-bit Avalon-MM slave bus plus timer irq
// Revision: 1.0
// =============================================================================
interface avalon_interval_timer_gen2_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic        irq;

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

endinterface
`default_nettype wire

// File: rtl/avalon_interval_timer_gen2_prescaler.sv
`default_nettype none
// =============================================================================
// timer_prescaler : divides clk by (prescale+1) while running, one-cycle tick
// Revision: 1.0
// =============================================================================
module timer_prescaler #(
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      run,
   input  logic                      load,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      tick
);

   logic [PRESCALE_WIDTH-1:0] r_pcount;

   assign tick = run & (r_pcount == '0);

   // Holding at prescale while stopped makes a restart begin a full prescale interval.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pcount <= '0;
      end else if (load || !run || tick) begin
         r_pcount <= prescale;
      end else begin
         r_pcount <= r_pcount - PRESCALE_WIDTH'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/avalon_interval_timer_gen2.sv
`default_nettype none
// =============================================================================
// avalon_interval_timer_gen2 : Avalon-MM interval timer with runtime period,
// prescaler, one-shot/continuous mode, start/stop strobes and counter snapshot
// Revision: 1.0
// =============================================================================
module avalon_interval_timer_gen2
   import avalon_timer_pkg::*;
#(
   parameter int COUNT_WIDTH    = 32,
   parameter int DEFAULT_PERIOD = 49999,
   parameter int PRESCALE_WIDTH = 8,
   parameter int RESET_RUNNING  = 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   avalon_interval_timer_gen2_if.slave   bus
);

   logic [COUNT_WIDTH-1:0]    r_period;
   logic [COUNT_WIDTH-1:0]    r_counter;
   logic [COUNT_WIDTH-1:0]    r_snap;
   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic                      r_to;
   logic                      r_run;
   logic                      r_ito;
   logic                      r_cont;
   logic                      r_reload;
   logic [15:0]               r_readdata;

   logic        w_wr;
   logic        w_wr_status;
   logic        w_wr_control;
   logic        w_wr_periodh;
   logic        w_wr_period;
   logic        w_wr_snap;
   logic        w_wr_prescale;
   logic        w_tick;
   logic        w_event;
   logic [31:0] w_period_ext;
   logic [31:0] w_snap_ext;
   logic [31:0] w_period_new;
   logic [15:0] w_rdata;

   assign w_wr          = bus.chipselect & ~bus.write_n;
   assign w_wr_status   = w_wr & (bus.address == ADDR_STATUS);
   assign w_wr_control  = w_wr & (bus.address == ADDR_CONTROL);
   assign w_wr_periodh  = w_wr & (bus.address == ADDR_PERIODH);
   assign w_wr_period   = w_wr_periodh | (w_wr & (bus.address == ADDR_PERIODL));
   assign w_wr_snap     = w_wr & ((bus.address == ADDR_SNAPL) | (bus.address == ADDR_SNAPH));
   assign w_wr_prescale = w_wr & (bus.address == ADDR_PRESCALE);

   assign w_period_ext = 32'(r_period);
   assign w_snap_ext   = 32'(r_snap);

   // A pending reload overrides the tick, so no timeout can fire in that cycle.
   assign w_event = w_tick & ~r_reload & (r_counter == '0);

   assign bus.irq      = r_to & r_ito;
   assign bus.readdata = r_readdata;

   // Bits above COUNT_WIDTH are dropped when the merged value is stored.
   always_comb begin
      w_period_new = w_period_ext;
      if (w_wr_periodh) begin
         w_period_new[31:16] = bus.writedata;
      end else begin
         w_period_new[15:0] = bus.writedata;
      end
   end

   timer_prescaler #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_prescaler (
      .clk      (clk),
      .reset_n  (reset_n),
      .run      (r_run),
      .load     (r_reload),
      .prescale (r_prescale),
      .tick     (w_tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_period   <= COUNT_WIDTH'(DEFAULT_PERIOD);
         r_counter  <= COUNT_WIDTH'(DEFAULT_PERIOD);
         r_snap     <= '0;
         r_prescale <= '0;
         r_to       <= 1'b0;
         r_run      <= (RESET_RUNNING != 0);
         r_ito      <= 1'b0;
         r_cont     <= (RESET_RUNNING != 0);
         r_reload   <= 1'b0;
      end else begin
         r_reload <= w_wr_period;
         if (w_wr_period) begin
            r_period <= w_period_new[COUNT_WIDTH-1:0];
         end
         if (w_wr_prescale) begin
            r_prescale <= bus.writedata[PRESCALE_WIDTH-1:0];
         end
         if (w_wr_snap) begin
            r_snap <= r_counter;
         end
         if (w_wr_control) begin
            r_ito  <= bus.writedata[CTRL_ITO];
            r_cont <= bus.writedata[CTRL_CONT];
         end

         if (r_reload) begin
            r_counter <= r_period;
         end else if (w_tick) begin
            if (r_counter == '0) begin
               r_counter <= r_period;
            end else begin
               r_counter <= r_counter - COUNT_WIDTH'(1);
            end
         end

         // Software strobes override the one-shot stop; STOP beats START.
         if (w_wr_control && bus.writedata[CTRL_STOP]) begin
            r_run <= 1'b0;
         end else if (w_wr_control && bus.writedata[CTRL_START]) begin
            r_run <= 1'b1;
         end else if (w_event) begin
            r_run <= r_cont;
         end

         if (w_event) begin
            r_to <= 1'b1;
         end else if (w_wr_status) begin
            r_to <= 1'b0;
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      case (bus.address)
         ADDR_STATUS: begin
            w_rdata[STAT_TO]  = r_to;
            w_rdata[STAT_RUN] = r_run;
         end
         ADDR_CONTROL: begin
            w_rdata[CTRL_ITO]  = r_ito;
            w_rdata[CTRL_CONT] = r_cont;
         end
         ADDR_PERIODL:  w_rdata = w_period_ext[15:0];
         ADDR_PERIODH:  w_rdata = w_period_ext[31:16];
         ADDR_SNAPL:    w_rdata = w_snap_ext[15:0];
         ADDR_SNAPH:    w_rdata = w_snap_ext[31:16];
         ADDR_PRESCALE: w_rdata = 16'(r_prescale);
         default:       w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= '0;
      end else begin
         r_readdata <= w_rdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_avalon_interval_timer_gen2.sv
`default_nettype none
// =============================================================================
// tb_avalon_interval_timer_gen2 : self-checking bench for the interval timer
// Revision: 1.0
// =============================================================================
module tb_avalon_interval_timer_gen2;
   import avalon_timer_pkg::*;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   cyc     = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   avalon_interval_timer_gen2_if bus();

   avalon_interval_timer_gen2 #(
      .COUNT_WIDTH    (32),
      .DEFAULT_PERIOD (49999),
      .PRESCALE_WIDTH (8),
      .RESET_RUNNING  (1)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      bit          is_wr;
      logic [2:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp;
      string       name;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called at a negedge; the write lands on the following posedge.
   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [15:0] d);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      @(negedge clk);
      d = bus.readdata;
      bus.chipselect = 1'b0;
   endtask

   vec_t        vecs[$];
   logic [15:0] rdv;
   logic [15:0] rdv2;

   initial begin
      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      chk("reset_irq", 32'(bus.irq), 32'd0);

      // Register defaults and basic access
      vecs.push_back('{0, ADDR_STATUS,   16'h0000, 16'h0002, "rst_status"});
      vecs.push_back('{0, ADDR_CONTROL,  16'h0000, 16'h0002, "rst_control"});
      vecs.push_back('{0, ADDR_PERIODL,  16'h0000, 16'hC34F, "rst_periodl"});
      vecs.push_back('{0, ADDR_PERIODH,  16'h0000, 16'h0000, "rst_periodh"});
      vecs.push_back('{0, ADDR_SNAPL,    16'h0000, 16'h0000, "rst_snapl"});
      vecs.push_back('{0, ADDR_SNAPH,    16'h0000, 16'h0000, "rst_snaph"});
      vecs.push_back('{0, ADDR_PRESCALE, 16'h0000, 16'h0000, "rst_prescale"});
      vecs.push_back('{0, 3'd7,          16'h0000, 16'h0000, "rst_reserved"});
      vecs.push_back('{1, ADDR_CONTROL,  16'h000C, 16'h0000, ""});
      vecs.push_back('{0, ADDR_STATUS,   16'h0000, 16'h0000, "startstop_status"});
      vecs.push_back('{0, ADDR_CONTROL,  16'h0000, 16'h0000, "startstop_control"});
      vecs.push_back('{1, ADDR_PRESCALE, 16'h01FF, 16'h0000, ""});
      vecs.push_back('{0, ADDR_PRESCALE, 16'h0000, 16'h00FF, "prescale_width"});
      vecs.push_back('{1, ADDR_PERIODH,  16'hABCD, 16'h0000, ""});
      vecs.push_back('{0, ADDR_PERIODH,  16'h0000, 16'hABCD, "periodh_rw"});
      vecs.push_back('{1, ADDR_PERIODL,  16'h1234, 16'h0000, ""});
      vecs.push_back('{0, ADDR_PERIODL,  16'h0000, 16'h1234, "periodl_rw"});
      vecs.push_back('{1, 3'd7,          16'hFFFF, 16'h0000, ""});
      vecs.push_back('{0, 3'd7,          16'h0000, 16'h0000, "reserved_rw"});
      vecs.push_back('{1, ADDR_CONTROL,  16'h0003, 16'h0000, ""});
      vecs.push_back('{0, ADDR_CONTROL,  16'h0000, 16'h0003, "control_rw"});
      vecs.push_back('{0, ADDR_STATUS,   16'h0000, 16'h0000, "no_start_status"});
      foreach (vecs[i]) begin
         if (vecs[i].is_wr) begin
            wr(vecs[i].addr, vecs[i].wdata);
         end else begin
            rd(vecs[i].addr, rdv);
            chk(vecs[i].name, 32'(rdv), 32'(vecs[i].exp));
         end
      end

      // Continuous mode, period 9, no prescale: timeouts every 10 clks
      wr(ADDR_PRESCALE, 16'h0000);
      wr(ADDR_STATUS,   16'h0000);
      wr(ADDR_PERIODL,  16'd9);
      wr(ADDR_PERIODH,  16'd0);
      wr(ADDR_CONTROL,  16'h0007);
      repeat (9) @(negedge clk);
      chk("cont_before_to", 32'(bus.irq), 32'd0);
      @(negedge clk);
      chk("cont_first_to", 32'(bus.irq), 32'd1);
      wr(ADDR_STATUS, 16'h0000);
      chk("cont_clear", 32'(bus.irq), 32'd0);
      repeat (8) @(negedge clk);
      chk("cont_before_2nd", 32'(bus.irq), 32'd0);
      @(negedge clk);
      chk("cont_second_to", 32'(bus.irq), 32'd1);
      repeat (9) @(negedge clk);
      wr(ADDR_STATUS, 16'h0000);
      chk("clear_vs_event", 32'(bus.irq), 32'd1);
      wr(ADDR_STATUS, 16'h0000);
      chk("clear_after_collision", 32'(bus.irq), 32'd0);
      wr(ADDR_CONTROL, 16'h000D);
      rd(ADDR_STATUS, rdv);
      chk("start_stop_run", 32'(rdv), 32'h0000);
      rd(ADDR_CONTROL, rdv);
      chk("strobes_read_zero", 32'(rdv), 32'h0001);

      // One-shot, period 4
      wr(ADDR_PERIODL, 16'd4);
      wr(ADDR_CONTROL, 16'h0001);
      wr(ADDR_CONTROL, 16'h0005);
      repeat (4) @(negedge clk);
      chk("oneshot_before_to", 32'(bus.irq), 32'd0);
      @(negedge clk);
      chk("oneshot_to", 32'(bus.irq), 32'd1);
      rd(ADDR_STATUS, rdv);
      chk("oneshot_status", 32'(rdv), 32'h0001);
      wr(ADDR_SNAPL, 16'h0000);
      rd(ADDR_SNAPL, rdv);
      chk("oneshot_counter", 32'(rdv), 32'd4);
      wr(ADDR_STATUS, 16'h0000);
      repeat (20) @(negedge clk);
      chk("oneshot_no_retrigger", 32'(bus.irq), 32'd0);

      // Asynchronous reset in the middle of a count
      wr(ADDR_PERIODL, 16'd3);
      wr(ADDR_CONTROL, 16'h0007);
      repeat (30) @(negedge clk);
      chk("irq_before_reset", 32'(bus.irq), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("async_reset_irq", 32'(bus.irq), 32'd0);
      chk("async_reset_readdata", 32'(bus.readdata), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      wr(ADDR_SNAPL, 16'h0000);
      rd(ADDR_SNAPL, rdv);
      chk("reset_counter_lo", 32'(rdv), 32'hC34F);
      rd(ADDR_SNAPH, rdv);
      chk("reset_counter_hi", 32'(rdv), 32'h0000);
      rd(ADDR_STATUS, rdv);
      chk("reset_status", 32'(rdv), 32'h0002);

      // Random period/prescale/mode: irq checked every cycle against event arithmetic
      for (int t = 0; t < 20; t++) begin
         int p, s, len, w, t0, ev, last_clear;
         bit cont, exp_irq;
         p    = $urandom_range(0, 20);
         s    = $urandom_range(0, 3);
         cont = 1'($urandom_range(0, 1));
         len  = (p + 1) * (s + 1);
         wr(ADDR_CONTROL,  16'h0009);
         wr(ADDR_PRESCALE, 16'(s));
         wr(ADDR_PERIODL,  16'(p));
         wr(ADDR_PERIODH,  16'h0000);
         wr(ADDR_STATUS,   16'h0000);
         wr(ADDR_CONTROL,  16'h0005 | (16'(cont) << 1));
         w          = cyc;
         t0         = w + len;
         last_clear = w;
         for (int k = 0; k < 3 * len + 5; k++) begin
            @(negedge clk);
            if (cyc < t0)  ev = -1;
            else if (cont) ev = t0 + ((cyc - t0) / len) * len;
            else           ev = t0;
            exp_irq = (ev >= 0) && (ev >= last_clear);
            chk($sformatf("rand_irq p=%0d s=%0d cont=%0d", p, s, cont), 32'(bus.irq), 32'(exp_irq));
            if ($urandom_range(0, 3) == 0) begin
               bus.address    = ADDR_STATUS;
               bus.writedata  = 16'h0000;
               bus.chipselect = 1'b1;
               bus.write_n    = 1'b0;
               last_clear     = cyc + 1;
            end else begin
               bus.chipselect = 1'b0;
               bus.write_n    = 1'b1;
            end
         end
         bus.chipselect = 1'b0;
         bus.write_n    = 1'b1;
      end

      // Random snapshot: stop after n cycles, counter = P - ticks so far
      for (int t = 0; t < 6; t++) begin
         int unsigned p, s, n, expv;
         p    = 32'h12345 + $urandom_range(0, 255);
         s    = $urandom_range(0, 3);
         n    = $urandom_range(0, 200);
         expv = p - (n + 1) / (s + 1);
         wr(ADDR_CONTROL,  16'h0008);
         wr(ADDR_PRESCALE, 16'(s));
         wr(ADDR_PERIODL,  p[15:0]);
         wr(ADDR_PERIODH,  p[31:16]);
         wr(ADDR_STATUS,   16'h0000);
         wr(ADDR_CONTROL,  16'h0006);
         repeat (n) @(negedge clk);
         wr(ADDR_CONTROL,  16'h000A);
         wr(ADDR_SNAPL,    16'h0000);
         rd(ADDR_SNAPL, rdv);
         rd(ADDR_SNAPH, rdv2);
         chk($sformatf("snap p=%0h s=%0d n=%0d", p, s, n), {16'(rdv2), rdv}, expv);
         repeat (5) @(negedge clk);
         rd(ADDR_SNAPL, rdv);
         chk("snap_hold", 32'(rdv), 32'(expv[15:0]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
